mjpeg_unfold_dma: RTL
=====================

// Module: mjpeg_unfold_dma
// PURPOSE
// - Memory-mapped accelerator in the DNN_MMAP window (0x4000_0000..0x4000_FFFF) beside the picorv32 core.
// - Reads the raw row-major 8-bit image (default base 0x0001_0000) through one shared memory port.
// - Writes it back as contiguous 8x8 blocks (default base 0x0002_0000), 16 words per block.
// - The block order is raster; the result is consumed by the DCT/quantise firmware or hardware stage.
// PARAMETERS
// - MMAP_BASE  32'h4000_0000  base address of the register window
// - DIM_W      16             width of the WIDTH/HEIGHT/counter registers
// - SRC_RST    32'h0001_0000  reset value of SRC
// - DST_RST    32'h0002_0000  reset value of DST
// PORTS
// - clk        in   1   single clock; all logic is on the rising edge
// - rst        in   1   synchronous, active-high reset
// - en         in   1   CPU address is inside the MMAP window
// - valid      in   1   CPU bus request
// - addr       in   32  CPU byte address
// - wstrb      in   4   CPU write strobes; 0 means a read
// - wdata      in   32  CPU write data
// - ready      out  1   CPU bus acknowledge, a 1-cycle pulse
// - rdata      out  32  CPU read data, valid while ready=1
// - mem_valid  out  1   memory request
// - mem_write  out  1   1=write, 0=read
// - mem_addr   out  32  word-aligned byte address
// - mem_wdata  out  32  memory write data
// - mem_ready  in   1   memory acknowledge; mem_rdata is valid in the same cycle
// - mem_rdata  in   32  memory read data
// BEHAVIOUR
// - Reset: ready=0, rdata=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0.
//   SRC=SRC_RST, DST=DST_RST, WIDTH=HEIGHT=0, busy=0, done=0, BLKCNT=0.
// - CPU slave: a request is valid&en&!ready. ready pulses high exactly 1 cycle later, then returns low.
//   Register offsets are addr[7:0]; writes use whole words and ignore wstrb granularity.
//   Unmapped offsets read as 0 and ignore writes.
// - Register map:
//   - 0x00 CTRL: bit0 START (write 1; reads 0), bit1 BUSY (read-only), bit2 DONE (sticky; write 1 to clear).
//   - 0x04 SRC and 0x08 DST: addr[1:0] forced to 0.
//   - 0x0C WIDTH and 0x10 HEIGHT: pixels; bits[2:0] are ignored, so each is truncated to a multiple of 8.
//   - 0x14 BLKCNT: read-only count of completed blocks.
// - SRC, DST, WIDTH and HEIGHT writes while busy=1 are ignored.
// - Parameters are latched when START is accepted.
// - START while busy=1 is ignored.
// - START with WIDTH<8 or HEIGHT<8: busy stays 0 and DONE sets on the next cycle.
// - A CTRL write with START=1 and DONE-clear=1 clears DONE, then sets BUSY; the new DONE is 0.
// - DMA FSM states: IDLE, RD0, RD1, WR0, WR1, NEXT, FIN.
//   - IDLE -> RD0 on an accepted START; BLKCNT<=0.
//   - RD0/RD1: mem_valid=1, mem_write=0, mem_addr = SRC + (by*8+r)*W + bx*8 (+4 in RD1).
//     The word is captured into buf0/buf1 in the mem_ready cycle.
//   - WR0/WR1: mem_write=1, mem_wdata=buf0/buf1, mem_addr = DST + blk*64 + r*8 (+4 in WR1).
//   - Each state advances on mem_ready.
//   - mem_valid drops for exactly 1 cycle between consecutive requests, so it never sees a stale ready.
//   - NEXT: r++ with return to RD0; when r wraps 7->0: BLKCNT++ and bx++.
//     bx wraps at W/8 with by++; by reaching H/8 -> FIN.
//   - FIN: busy<=0, DONE<=1, -> IDLE.
// - Arithmetic: address offsets are 32-bit unsigned and wrap modulo 2^32 (never checked).
//   W = WIDTH & ~7, H = HEIGHT & ~7.
// - Latency per block: 32 memory transactions; each takes 2 cycles at minimum, plus 8 NEXT cycles.
// - rst mid-transfer: the transfer aborts; mem_valid=0 on the cycle after rst; no further writes are issued.
// - mem_ready outside an active request is ignored.
// STRUCTURE
// - Package mjpeg_pkg holds:
//   - register offset localparams: REG_CTRL, REG_SRC, REG_DST, REG_WIDTH, REG_HEIGHT, REG_BLKCNT;
//   - CTRL bit indices;
//   - DMA state encoding;
//   - BLK_DIM=8, BLK_WORDS=16.
// - Sub-module mjpeg_dma_regs holds the CPU-slave register file, start/done logic and parameter latch.
// - The top level holds the DMA FSM, counters r/bx/by, buf0/buf1 and address generation.
// TESTING
// - Register access: write SRC=0x10003 -> read 0x10000; ready is high 1 cycle after valid; read 0x20 -> 0.
// - Single block: W=8, H=8, source bytes 0..63 at 0x10000 -> DST words are 0x03020100 .. 0x3F3E3D3C.
//   BLKCNT=1; DONE=1 after exactly 32 transactions.
// - Unfold order: W=16, H=16, byte value = (y*16+x).
//   - Block 1 word 0 at DST+64 = 0x0B0A0908.
//   - Block 2 word 0 = 0x83828180.
//   - BLKCNT=4.
// - Boundary: WIDTH=13 behaves as W=8.
//   - HEIGHT=5: DONE is set 1 cycle after START, with no mem_valid.
//   - START while busy and SRC writes while busy: no effect.
// - Memory backpressure: mem_ready delayed 0..5 random cycles -> output is identical to zero-wait.
//   mem_valid is held stable until ready.
// - rst asserted after 10 transactions -> mem_valid=0 the next cycle; busy=0, DONE=0.
//   A fresh START completes correctly.

Source files
------------

// File: rtl/mjpeg_pkg.sv
// Shared constants and types for the MJPEG 8x8 block unfold DMA.
package mjpeg_pkg;

    // Register offsets within the MMAP window (addr[7:0])
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_SRC    = 8'h04;
    localparam logic [7:0] REG_DST    = 8'h08;
    localparam logic [7:0] REG_WIDTH  = 8'h0C;
    localparam logic [7:0] REG_HEIGHT = 8'h10;
    localparam logic [7:0] REG_BLKCNT = 8'h14;

    // CTRL bit positions
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_BUSY  = 1;
    localparam int unsigned CTRL_DONE  = 2;

    // Block geometry: 8x8 bytes, stored as 16 words
    localparam int unsigned BLK_DIM   = 8;
    localparam int unsigned BLK_WORDS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_NEXT,
        S_FIN
    } dma_state_t;

endpackage

// File: rtl/mjpeg_dma_regs.sv
// CPU-slave register file: CTRL/SRC/DST/WIDTH/HEIGHT/BLKCNT, start/done logic, parameter latch.
module mjpeg_dma_regs
    import mjpeg_pkg::*;
#(
    parameter logic [31:0] MMAP_BASE = 32'h4000_0000,
    parameter int unsigned DIM_W     = 16,
    parameter logic [31:0] SRC_RST   = 32'h0001_0000,
    parameter logic [31:0] DST_RST   = 32'h0002_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid,
    input  logic [31:0]      addr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    output logic             ready,
    output logic [31:0]      rdata,
    input  logic [DIM_W-1:0] blkcnt,
    input  logic             fin,
    output logic             start,
    output logic             busy,
    output logic [31:0]      p_src,
    output logic [31:0]      p_dst,
    output logic [DIM_W-1:0] p_w,
    output logic [DIM_W-1:0] p_h
);

    logic             done;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;

    logic             req;
    logic             wr;
    logic [7:0]       off;
    logic             ctrl_wr;
    logic             start_acc;
    logic             too_small;
    logic [31:0]      rd_val;
    logic             unused_addr;

    // Bus decode; offsets alias across addr[15:8] inside the window
    assign off         = addr[7:0];
    assign req         = valid & en & ~ready & (addr[31:16] == MMAP_BASE[31:16]);
    assign wr          = req & (wstrb != 4'b0000);
    assign ctrl_wr     = wr & (off == REG_CTRL);
    assign start_acc   = ctrl_wr & wdata[CTRL_START] & ~busy;
    assign too_small   = (width[DIM_W-1:3] == '0) | (height[DIM_W-1:3] == '0);
    assign unused_addr = ^addr[15:8];

    // Read mux; unmapped offsets return zero
    always_comb begin
        rd_val = '0;
        case (off)
            REG_CTRL: begin
                rd_val[CTRL_BUSY] = busy;
                rd_val[CTRL_DONE] = done;
            end
            REG_SRC:    rd_val = src;
            REG_DST:    rd_val = dst;
            REG_WIDTH:  rd_val = 32'(width);
            REG_HEIGHT: rd_val = 32'(height);
            REG_BLKCNT: rd_val = 32'(blkcnt);
            default:    rd_val = '0;
        endcase
    end

    // Register file, handshake, start/done/busy and parameter latch
    always_ff @(posedge clk) begin
        if (rst) begin
            ready  <= 1'b0;
            rdata  <= '0;
            start  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            src    <= SRC_RST;
            dst    <= DST_RST;
            width  <= '0;
            height <= '0;
            p_src  <= SRC_RST;
            p_dst  <= DST_RST;
            p_w    <= '0;
            p_h    <= '0;
        end else begin
            ready <= req;
            rdata <= (req && !wr) ? rd_val : '0;
            start <= 1'b0;
            if (wr && !busy) begin
                case (off)
                    REG_SRC:    src    <= {wdata[31:2], 2'b00};
                    REG_DST:    dst    <= {wdata[31:2], 2'b00};
                    REG_WIDTH:  width  <= {wdata[DIM_W-1:3], 3'b000};
                    REG_HEIGHT: height <= {wdata[DIM_W-1:3], 3'b000};
                    default: ;
                endcase
            end
            if (ctrl_wr && wdata[CTRL_DONE]) begin
                done <= 1'b0;
            end
            if (start_acc) begin
                if (too_small) begin
                    done <= 1'b1;
                end else begin
                    busy  <= 1'b1;
                    start <= 1'b1;
                    p_src <= src;
                    p_dst <= dst;
                    p_w   <= width;
                    p_h   <= height;
                end
            end
            if (fin) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mjpeg_unfold_dma.sv
// Raster image to contiguous 8x8 block unfold DMA with a CPU register window.
module mjpeg_unfold_dma
    import mjpeg_pkg::*;
#(
    parameter logic [31:0] MMAP_BASE = 32'h4000_0000,
    parameter int unsigned DIM_W     = 16,
    parameter logic [31:0] SRC_RST   = 32'h0001_0000,
    parameter logic [31:0] DST_RST   = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    dma_state_t       state;
    logic [2:0]       r;
    logic [DIM_W-1:0] bx;
    logic [DIM_W-1:0] by;
    logic [DIM_W-1:0] blkcnt;
    logic [31:0]      buf0;
    logic [31:0]      buf1;

    logic             start;
    logic             busy;
    logic             fin;
    logic [31:0]      p_src;
    logic [31:0]      p_dst;
    logic [DIM_W-1:0] p_w;
    logic [DIM_W-1:0] p_h;

    logic [31:0]      rd_addr;
    logic [31:0]      wr_addr;
    logic             last_col;
    logic             last_row;
    logic             unused_busy;

    assign fin         = (state == S_FIN);
    assign unused_busy = busy;

    mjpeg_dma_regs #(
        .MMAP_BASE (MMAP_BASE),
        .DIM_W     (DIM_W),
        .SRC_RST   (SRC_RST),
        .DST_RST   (DST_RST)
    ) u_regs (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .valid  (valid),
        .addr   (addr),
        .wstrb  (wstrb),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .blkcnt (blkcnt),
        .fin    (fin),
        .start  (start),
        .busy   (busy),
        .p_src  (p_src),
        .p_dst  (p_dst),
        .p_w    (p_w),
        .p_h    (p_h)
    );

    // Source row address and destination block-row address; all wrap modulo 2^32
    always_comb begin
        rd_addr  = p_src
                 + (32'(by) * 32'(BLK_DIM) + 32'(r)) * 32'(p_w)
                 + 32'(bx) * 32'(BLK_DIM);
        wr_addr  = p_dst
                 + 32'(blkcnt) * 32'(BLK_WORDS * 4)
                 + 32'(r) * 32'(BLK_DIM);
        last_col = ((bx + DIM_W'(1)) == (p_w >> 3));
        last_row = ((by + DIM_W'(1)) == (p_h >> 3));
    end

    // DMA sequencer; each request is raised from a low mem_valid so a stale ready is never seen
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r         <= '0;
            bx        <= '0;
            by        <= '0;
            blkcnt    <= '0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RD0;
                        r      <= '0;
                        bx     <= '0;
                        by     <= '0;
                        blkcnt <= '0;
                    end
                end
                S_RD0, S_RD1: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= (state == S_RD1) ? rd_addr + 32'd4 : rd_addr;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (state == S_RD0) begin
                            buf0  <= mem_rdata;
                            state <= S_RD1;
                        end else begin
                            buf1  <= mem_rdata;
                            state <= S_WR0;
                        end
                    end
                end
                S_WR0, S_WR1: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_write <= 1'b1;
                        mem_addr  <= (state == S_WR1) ? wr_addr + 32'd4 : wr_addr;
                        mem_wdata <= (state == S_WR1) ? buf1 : buf0;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= (state == S_WR0) ? S_WR1 : S_NEXT;
                    end
                end
                S_NEXT: begin
                    state <= S_RD0;
                    if (r == 3'd7) begin
                        r      <= '0;
                        blkcnt <= blkcnt + DIM_W'(1);
                        if (last_col) begin
                            bx <= '0;
                            if (last_row) begin
                                state <= S_FIN;
                            end else begin
                                by <= by + DIM_W'(1);
                            end
                        end else begin
                            bx <= bx + DIM_W'(1);
                        end
                    end else begin
                        r <= r + 3'd1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
